// File: rtl/serial_compare_ctrl.sv
// Bit-serial magnitude comparator: accepts an operand pair, walks it MSB-first
// through the gt/eq/lt ripple cell one bit per clock, then holds the result.
module serial_compare_ctrl #(
   parameter int WIDTH      = 32,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             agtb,
   output logic             aeqb,
   output logic             altb,
   output logic             busy
);

   localparam int IW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_reg, a_next;
   logic [WIDTH-1:0] b_reg, b_next;
   logic [IW-1:0]    idx_reg, idx_next;
   logic             gt_reg, gt_next;
   logic             eq_reg, eq_next;
   logic             lt_reg, lt_next;
   logic             agtb_reg, agtb_next;
   logic             aeqb_reg, aeqb_next;
   logic             altb_reg, altb_next;

   logic [WIDTH-1:0] a_load, b_load;
   logic             a_bit, b_bit;
   logic             gt_step, eq_step, lt_step;
   logic             last_step;

   // Flipping both sign bits maps two's-complement order onto unsigned order,
   // so the serial walk never needs to know about signedness.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_load
         if (gi == WIDTH - 1) begin : g_msb
            assign a_load[gi] = a[gi] ^ is_signed;
            assign b_load[gi] = b[gi] ^ is_signed;
         end else begin : g_rest
            assign a_load[gi] = a[gi];
            assign b_load[gi] = b[gi];
         end
      end
   endgenerate

   assign a_bit   = a_reg[idx_reg];
   assign b_bit   = b_reg[idx_reg];
   assign gt_step = gt_reg | (eq_reg & a_bit & ~b_bit);
   assign lt_step = lt_reg | (eq_reg & ~a_bit & b_bit);
   assign eq_step = eq_reg & (a_bit ~^ b_bit);

   assign last_step = (idx_reg == '0) || (EARLY_EXIT && !eq_step);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         gt_reg    <= 1'b0;
         eq_reg    <= 1'b1;
         lt_reg    <= 1'b0;
         agtb_reg  <= 1'b0;
         aeqb_reg  <= 1'b0;
         altb_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         gt_reg    <= gt_next;
         eq_reg    <= eq_next;
         lt_reg    <= lt_next;
         agtb_reg  <= agtb_next;
         aeqb_reg  <= aeqb_next;
         altb_reg  <= altb_next;
      end
   end

   // Operand shadow registers carry no control meaning, so they skip reset.
   always_ff @(posedge clk) begin
      a_reg <= a_next;
      b_reg <= b_next;
   end

   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      idx_next   = idx_reg;
      gt_next    = gt_reg;
      eq_next    = eq_reg;
      lt_next    = lt_reg;
      agtb_next  = agtb_reg;
      aeqb_next  = aeqb_reg;
      altb_next  = altb_reg;

      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               a_next     = a_load;
               b_next     = b_load;
               idx_next   = IW'(WIDTH - 1);
               gt_next    = 1'b0;
               eq_next    = 1'b1;
               lt_next    = 1'b0;
               state_next = RUN;
            end
         end
         RUN: begin
            gt_next = gt_step;
            eq_next = eq_step;
            lt_next = lt_step;
            if (last_step) begin
               agtb_next  = gt_step;
               aeqb_next  = eq_step;
               altb_next  = lt_step;
               state_next = DONE;
            end else begin
               idx_next = idx_reg - IW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign busy      = (state_reg == RUN);
   assign agtb      = agtb_reg;
   assign aeqb      = aeqb_reg;
   assign altb      = altb_reg;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Scoreboard bench for serial_compare_ctrl: stimulus pushes expected results,
// a negedge monitor pops and checks flags, latency and handshake behaviour.
module tb_serial_compare_ctrl;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         is_signed = 1'b0;
   logic         out_valid;
   logic         out_ready;
   logic         agtb, aeqb, altb, busy;

   logic         f_in_valid = 1'b0;
   logic         f_in_ready;
   logic [W-1:0] f_a = '0;
   logic [W-1:0] f_b = '0;
   logic         f_is_signed = 1'b0;
   logic         f_out_valid;
   logic         f_out_ready = 1'b1;
   logic         f_agtb, f_aeqb, f_altb, f_busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int ready_mode = 1;
   int n_sent = 0;
   int n_dropped = 0;
   int nres = 0;

   typedef struct {
      logic [2:0]   flags;
      int           lat;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         s;
   } exp_t;

   exp_t exp_q[$];
   int   acc_q[$];

   serial_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
      .out_ready(out_ready), .agtb(agtb), .aeqb(aeqb), .altb(altb), .busy(busy)
   );

   serial_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_fx (
      .clk(clk), .rst(rst), .in_valid(f_in_valid), .in_ready(f_in_ready),
      .a(f_a), .b(f_b), .is_signed(f_is_signed), .out_valid(f_out_valid),
      .out_ready(f_out_ready), .agtb(f_agtb), .aeqb(f_aeqb), .altb(f_altb), .busy(f_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [2:0] ref_flags(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s);
      if (s) return {$signed(x) > $signed(y), x == y, $signed(x) < $signed(y)};
      return {x > y, x == y, x < y};
   endfunction

   function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] d;
      d = x ^ y;
      for (int k = W - 1; k >= 0; k--) begin
         if (d[k]) return W - k + 1;
      end
      return W + 1;
   endfunction

   // out_ready driver: 0 = held low, 1 = held high, 2 = random
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor
   initial begin
      logic       in_result;
      logic [2:0] held;
      exp_t       e;
      int         t;
      int         lat;
      in_result = 1'b0;
      held = 3'b000;
      forever begin
         @(negedge clk);
         if (rst) begin
            in_result = 1'b0;
         end else begin
            if (in_valid && in_ready) acc_q.push_back(cyc + 1);
            if (out_valid) begin
               chk("in_ready_low_in_done", in_ready, 0);
               chk("onehot", $countones({agtb, aeqb, altb}), 1);
               if (!in_result) begin
                  in_result = 1'b1;
                  held = {agtb, aeqb, altb};
                  if (exp_q.size() == 0 || acc_q.size() == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL spurious_result: got flags %b required no result", held);
                  end else begin
                     e = exp_q.pop_front();
                     t = acc_q.pop_front();
                     lat = cyc - t + 1;
                     nres++;
                     $display("result %0d: a=%h b=%h signed=%0d gt/eq/lt=%b latency=%0d",
                              nres, e.a, e.b, e.s, held, lat);
                     chk("flags", held, e.flags);
                     if (e.lat >= 0) chk("latency", lat, e.lat);
                  end
               end else begin
                  chk("hold_stable", {agtb, aeqb, altb}, held);
               end
               if (out_ready) in_result = 1'b0;
            end else begin
               in_result = 1'b0;
            end
         end
      end
   end

   task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs,
                       input logic [2:0] flags, input int lat);
      exp_t e;
      int   n;
      e.a = va; e.b = vb; e.s = vs; e.flags = flags; e.lat = lat;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b1; a = va; b = vb; is_signed = vs;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout: got in_ready=0 required 1 within 300 cycles");
         void'(exp_q.pop_back());
      end else begin
         n_sent++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      is_signed = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (!(exp_q.size() == 0 && in_ready && !out_valid) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         checks++;
         failures++;
         $display("FAIL idle_timeout: got pending=%0d required 0", exp_q.size());
      end
   endtask

   task automatic fx(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [2:0] flags);
      int lat;
      @(posedge clk);
      #1;
      f_in_valid = 1'b1; f_a = va; f_b = vb;
      @(negedge clk);
      chk("fx_in_ready", f_in_ready, 1);
      @(posedge clk);
      #1;
      f_in_valid = 1'b0; f_a = $urandom; f_b = $urandom;
      lat = 1;
      @(negedge clk);
      while (!f_out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      $display("fixed: a=%h b=%h gt/eq/lt=%b latency=%0d", va, vb, {f_agtb, f_aeqb, f_altb}, lat);
      chk("fx_latency", lat, W + 1);
      chk("fx_flags", {f_agtb, f_aeqb, f_altb}, flags);
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         bcount;
      int         n;
      int         r;
      logic [W-1:0] va, vb;
      logic       vs;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_flags", {agtb, aeqb, altb}, 3'b000);

      // Equal operands: full latency, busy for cycles 1..32
      send(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 3'b010, 33);
      bcount = 0;
      for (int i = 1; i <= 34; i++) begin
         @(negedge clk);
         if (busy) bcount++;
         if (i == 1) chk("busy_cycle1", busy, 1);
      end
      chk("busy_cycles", bcount, 32);
      wait_idle();

      send(32'h80000000, 32'h7FFFFFFF, 1'b0, 3'b100, 2);
      send(32'h80000000, 32'h7FFFFFFF, 1'b1, 3'b001, 2);
      send(32'h00000001, 32'h00000000, 1'b0, 3'b100, 33);
      send(32'hFFFFFFFF, 32'h00000001, 1'b1, 3'b001, 2);
      send(32'hFFFFFFFF, 32'h00000001, 1'b0, 3'b100, 2);
      send(32'h7FFFFFFF, 32'h7FFFFFFE, 1'b1, 3'b100, 33);
      send(32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 3'b001, 33);
      send(32'h00000005, 32'h00000009, 1'b0, 3'b001, 30);
      wait_idle();

      // Backpressure in DONE
      ready_mode = 0;
      send(32'h00000100, 32'h00000200, 1'b0, 3'b001, 24);
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("bp_reached_done", out_valid, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_flags", {agtb, aeqb, altb}, 3'b001);
      end
      @(posedge clk);
      ready_mode = 1;
      @(negedge clk);
      chk("bp_valid_until_taken", out_valid, 1);
      @(negedge clk);
      chk("bp_in_ready_after", in_ready, 1);
      chk("bp_valid_dropped", out_valid, 0);
      chk("bp_flags_kept", {agtb, aeqb, altb}, 3'b001);

      // Reset in the middle of a compare
      send(32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 3'b010, 33);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      acc_q.delete();
      n_dropped++;
      @(negedge clk);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_flags", {agtb, aeqb, altb}, 3'b000);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      send(32'h00000005, 32'h00000009, 1'b0, 3'b001, 30);
      wait_idle();

      // Random back-to-back with random out_ready
      ready_mode = 2;
      for (int i = 0; i < 1000; i++) begin
         va = $urandom;
         r = $urandom_range(0, 3);
         if (r == 0) vb = va;
         else if (r == 1) vb = va ^ (32'h1 << $urandom_range(0, W - 1));
         else vb = $urandom;
         vs = 1'($urandom_range(0, 1));
         send(va, vb, vs, ref_flags(va, vb, vs), ref_lat(va, vb));
      end
      ready_mode = 1;
      wait_idle();
      chk("scoreboard_drained", exp_q.size(), 0);
      chk("result_count", nres, n_sent - n_dropped);

      // Fixed-latency instance
      fx(32'h00000010, 32'h00000011, 3'b001);
      fx(32'h80000000, 32'h7FFFFFFF, 3'b100);
      fx(32'h00000005, 32'h00000005, 3'b010);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_compare_ctrl.md
Name: serial_compare_ctrl

Overview:
Bit-serial magnitude comparator controller. It accepts one operand pair through a valid/ready handshake, walks the operands MSB-first one bit per clock, and produces the gt/eq/lt result through an output valid/ready handshake. Each step applies the same per-bit cell as the existing ripple comparator (gt/eq/lt chain, seeded 0/1/0), so the ALU can trade the 32-stage combinational compare for a small sequential unit. It supports unsigned and two's-complement signed compares, and can optionally exit early once the result is decided.

Parameters:
WIDTH, 32, operand width in bits; minimum 2.
EARLY_EXIT, 1, 1 = finish on the first differing bit; 0 = always process all WIDTH bits (fixed latency).

Ports:
clk  input  1  clock; single clock domain.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand pair valid.
in_ready  output  1  controller can accept an operand pair.
a  input  WIDTH  operand A; sampled only on accept.
b  input  WIDTH  operand B; sampled only on accept.
is_signed  input  1  1 = two's-complement compare; sampled on accept.
out_valid  output  1  result valid.
out_ready  input  1  consumer takes the result.
agtb  output  1  A > B.
aeqb  output  1  A == B.
altb  output  1  A < B.
busy  output  1  high while a compare is running (RUN state).

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high: rst is sampled on the rising edge of clk.
- While rst is high, on each rising edge: state <= IDLE, out_valid <= 0, agtb <= 0, aeqb <= 0, altb <= 0, busy <= 0, and the internal chain resets to gt=0/eq=1/lt=0. This holds even mid-RUN or mid-DONE: the operation is dropped and no result is produced.
- in_ready = (state == IDLE). It is 1 in the first cycle after rst deasserts.
- State IDLE:
  - Accept occurs when in_valid && in_ready.
  - On accept: latch a and b into shift/index registers and latch is_signed.
  - When signed, invert the latched MSB of both operands; this reuses the unsigned path.
  - Set idx <= WIDTH-1, chain <= 0/1/0, go to RUN.
- State RUN, one bit per cycle at index idx:
  - gt' = gt | (eq & a[idx] & ~b[idx])
  - lt' = lt | (eq & ~a[idx] & b[idx])
  - eq' = eq & (a[idx] ~^ b[idx])
  - Go to DONE if idx == 0, or if EARLY_EXIT == 1 and eq' == 0. Otherwise idx <= idx-1.
  - Exactly one of gt'/eq'/lt' is high at all times.
- State DONE:
  - out_valid = 1; agtb/aeqb/altb are registered and hold the final chain.
  - Outputs stay stable while out_valid && !out_ready.
  - On out_ready: go to IDLE; out_valid drops the next cycle; result outputs keep their last values.
- Latency, with accept edge = cycle 0:
  - Full-width compare: out_valid in cycle WIDTH+1.
  - EARLY_EXIT with the first differing bit at index k: out_valid in cycle WIDTH-k+1.
  - Equal operands: always WIDTH+1.
- No overlap: no new accept while in RUN or DONE.
- Minimum spacing between accepts is latency+1 cycles when out_ready is held high.
- a, b and is_signed are don't-care outside the accept cycle. Changes to them during RUN do not affect the result.
- out_ready asserted outside DONE is ignored.

Test Plan:
- Equal operands: a=b=0xDEADBEEF, unsigned, out_ready=1 -> out_valid at cycle 33 with agtb=0, aeqb=1, altb=0; busy high for cycles 1..32.
- MSB difference: a=0x80000000, b=0x7FFFFFFF, unsigned -> agtb=1, and out_valid at cycle 2 with EARLY_EXIT=1. Same pair with is_signed=1 -> altb=1, also at cycle 2.
- LSB difference, fixed latency: a=0x00000001, b=0x00000000, EARLY_EXIT=1 -> agtb=1 at cycle 33. a=0x00000010, b=0x00000011 with EARLY_EXIT=0 -> altb=1 at cycle 33.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and results stable and in_ready=0 throughout; raise out_ready -> in_ready=1 on the next cycle.
- Reset mid-RUN: rst=1 at cycle 10 of a compare -> cycle after: out_valid=0, all flags 0, busy=0, in_ready=1; a new pair (a=5, b=9) then yields altb=1.
- Back-to-back random: 1000 random pairs with mixed is_signed and random out_ready -> results match the reference $signed/$unsigned compare, exactly one flag high per result, no lost or duplicated results.
